// File: rtl/serial_subtractor10.sv
// Chunked multi-cycle subtractor: diff = a - b - bin, K bits per cycle with a
// registered borrow between chunks, behind valid/ready handshakes.
module serial_subtractor10 #(
    parameter int N = 32,
    parameter int K = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ovf
);
    localparam int CHUNKS = N / K;
    localparam int IW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [N-1:0]  a_r, b_r;
    logic          borrow;
    logic [IW-1:0] idx;
    logic [31:0]   off;
    logic [K-1:0]  a_chunk, b_chunk;
    logic [K:0]    sum;
    logic          last;

    assign off     = 32'(idx) * 32'(K);
    assign a_chunk = K'(a_r >> off);
    assign b_chunk = K'(b_r >> off);
    // a + ~b + !borrow: carry out of the chunk means no borrow into the next
    assign sum     = {1'b0, a_chunk} + {1'b0, ~b_chunk} + {{K{1'b0}}, ~borrow};
    assign last    = (idx == IW'(CHUNKS - 1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            borrow <= 1'b0;
            idx    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r    <= a;
                        b_r    <= b;
                        borrow <= bin;
                        idx    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    diff[off +: K] <= sum[K-1:0];
                    borrow         <= ~sum[K];
                    if (last) begin
                        idx   <= '0;
                        bout  <= ~sum[K];
                        // the final chunk carries the sign bit of the result
                        ovf   <= (a_r[N-1] != b_r[N-1]) && (sum[K-1] != a_r[N-1]);
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor10.sv
// Directed bench for serial_subtractor10: an arithmetic/timing model is checked
// every cycle, plus literal expectations for each directed vector.
module tb_serial_subtractor10;
    localparam int N = 32;
    localparam int K = 8;
    localparam int LAT = N / K;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;

    int errors = 0;
    int checks = 0;

    serial_subtractor10 #(.N(N), .K(K)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: whole-word arithmetic plus a cycle count for latency.
    logic         m_seen = 1'b0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    int           m_left = 0;
    logic [N-1:0] m_diff = '0;
    logic         m_bout = 1'b0;
    logic         m_ovf  = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_seen <= 1'b1;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
        end else if (m_done) begin
            if (out_ready) m_done <= 1'b0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end
        end else if (in_valid) begin
            logic [N:0] full;
            full = {1'b0, a} - {1'b0, b} - (N+1)'(bin);
            m_busy <= 1'b1;
            m_left <= LAT;
            m_diff <= full[N-1:0];
            m_bout <= full[N];
            m_ovf  <= (a[N-1] != b[N-1]) && (full[N-1] != a[N-1]);
        end
    end

    always @(negedge clk) begin
        if (m_seen) begin
            chk("model in_ready", 64'(in_ready), 64'(!m_busy && !m_done));
            chk("model out_valid", 64'(out_valid), 64'(m_done));
            if (m_done) begin
                chk("model diff", 64'(diff), 64'(m_diff));
                chk("model bout", 64'(bout), 64'(m_bout));
                chk("model ovf", 64'(ovf), 64'(m_ovf));
            end
        end
    end

    // Accept one operation; returns with out_valid observed high (#1 after its edge).
    task automatic start_op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic bi,
                            input logic rdy, input string name);
        int lat;
        @(negedge clk);
        a = av; b = bv; bin = bi; in_valid = 1'b1; out_ready = rdy;
        @(posedge clk);
        #1;
        lat = 0;
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, " latency"}, 64'(lat), 64'(LAT));
    endtask

    task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic bi,
                          input logic [N-1:0] ed, input logic eb, input logic eo, input string name);
        start_op(av, bv, bi, 1'b1, name);
        chk({name, " diff"}, 64'(diff), 64'(ed));
        chk({name, " bout"}, 64'(bout), 64'(eb));
        chk({name, " ovf"}, 64'(ovf), 64'(eo));
        @(posedge clk);
        #1;
        chk({name, " out_valid drop"}, 64'(out_valid), 64'd0);
        chk({name, " in_ready back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [N-1:0] hd;
        logic hb, ho;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset diff", 64'(diff), 64'd0);
        chk("reset bout", 64'(bout), 64'd0);
        chk("reset ovf", 64'(ovf), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);

        run_op(32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0, "basic");
        run_op(32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, "underflow");
        run_op(32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, "ovf_neg");
        run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1, "ovf_pos");
        run_op(32'h00010000, 32'h00000000, 1'b1, 32'h0000FFFF, 1'b0, 1'b0, "xchunk");
        run_op(32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, "xchunk_all");
        run_op(32'h12345678, 32'h00FF00FF, 1'b1, 32'h11355578, 1'b0, 1'b0, "mixed");

        // Back-pressure: result held while inputs churn.
        start_op(32'h00000100, 32'h00000001, 1'b0, 1'b0, "bp");
        hd = diff; hb = bout; ho = ovf;
        chk("bp diff", 64'(diff), 64'h000000FF);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            a = $urandom;
            chk("bp out_valid", 64'(out_valid), 64'd1);
            chk("bp in_ready", 64'(in_ready), 64'd0);
            chk("bp hold", 64'({diff, bout, ovf}), 64'({hd, hb, ho}));
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp still valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        chk("bp release", 64'(out_valid), 64'd0);
        chk("bp no accept", 64'(in_ready), 64'd1);

        // Reset during chunk 2 of a run.
        @(negedge clk);
        a = 32'hDEADBEEF; b = 32'h01234567; bin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid in_ready", 64'(in_ready), 64'd1);
        chk("rst_mid out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid outs", 64'({diff, bout, ovf}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd10, 32'd4, 1'b0, 32'd6, 1'b0, 1'b0, "after_rst");

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
